// File: rtl/m_axis_pattern_gen.sv
// AXI4-Stream master test-pattern source: NPKT packets of LEN beats separated by GAP idle cycles,
// with runtime-selectable data pattern and full tvalid/tready hold behaviour.
module m_axis_pattern_gen #(
    parameter int          DWIDTH = 32,
    parameter int          LENW   = 16,
    parameter int          GAPW   = 8,
    parameter int          PKTW   = 16,
    parameter logic [31:0] SEED   = 32'h0000_0001
) (
    input  logic                  clk,
    input  logic                  xrst,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [LENW-1:0]       len,
    input  logic [GAPW-1:0]       gap,
    input  logic [PKTW-1:0]       npkt,
    input  logic                  tready,
    output logic                  tvalid,
    output logic [DWIDTH-1:0]     tdata,
    output logic [DWIDTH/8-1:0]   tstrb,
    output logic                  tlast,
    output logic                  busy,
    output logic                  done
);

    localparam logic [31:0]       LFSR_MASK = 32'h8020_0003;
    localparam logic [31:0]       LFSR_INIT = (SEED == 32'h0000_0000) ? 32'h0000_0001 : SEED;
    localparam logic [LENW-1:0]   ONE_L     = LENW'(1'b1);
    localparam logic [GAPW-1:0]   ONE_G     = GAPW'(1'b1);
    localparam logic [PKTW-1:0]   ONE_P     = PKTW'(1'b1);
    localparam logic [DWIDTH-1:0] ONE_D     = DWIDTH'(1'b1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
        lfsr_step = (cur >> 1) ^ (cur[0] ? LFSR_MASK : 32'h0000_0000);
    endfunction

    // Data word for a beat given its in-packet index, running count and current LFSR value.
    function automatic logic [DWIDTH-1:0] beat_data(input logic [1:0]        m,
                                                    input logic [LENW-1:0]   b,
                                                    input logic [DWIDTH-1:0] r,
                                                    input logic [31:0]       l);
        case (m)
            2'd0:    beat_data = DWIDTH'(b) + ONE_D;
            2'd1:    beat_data = r + ONE_D;
            2'd2:    beat_data = DWIDTH'(l);
            2'd3:    beat_data = {(DWIDTH/8){8'hA5}};
            default: beat_data = {DWIDTH{1'b0}};
        endcase
    endfunction

    state_t             state_r, state_s;
    logic [1:0]         mode_r, mode_s;
    logic [LENW-1:0]    len_r, len_s;
    logic [GAPW-1:0]    gap_r, gap_s;
    logic [PKTW-1:0]    npkt_r, npkt_s;
    logic [LENW-1:0]    beat_r, beat_s;
    logic [PKTW-1:0]    pkt_r, pkt_s;
    logic [GAPW-1:0]    gcnt_r, gcnt_s;
    logic [DWIDTH-1:0]  run_r, run_s;
    logic [31:0]        lfsr_r, lfsr_s;
    logic [DWIDTH-1:0]  tdata_r, tdata_s;
    logic               tlast_r, tlast_s;
    logic               tvalid_r, tvalid_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;

    logic               xfer_s;
    logic               last_beat_s;
    logic               last_pkt_s;
    logic [LENW-1:0]    len_m1_s;
    logic [31:0]        lfsr_adv_s;

    assign xfer_s      = tvalid_r & tready;
    assign len_m1_s    = len_r - ONE_L;
    assign last_beat_s = (beat_r == len_m1_s);
    // npkt of zero never matches, so the run continues until reset
    assign last_pkt_s  = (npkt_r != {PKTW{1'b0}}) && (pkt_r == (npkt_r - ONE_P));
    // The LFSR only moves on transfers of an LFSR-mode run so its sequence is contiguous across runs
    assign lfsr_adv_s  = (mode_r == 2'd2) ? lfsr_step(lfsr_r) : lfsr_r;

    // Next-state and next-output logic
    always_comb begin
        state_s  = state_r;
        mode_s   = mode_r;
        len_s    = len_r;
        gap_s    = gap_r;
        npkt_s   = npkt_r;
        beat_s   = beat_r;
        pkt_s    = pkt_r;
        gcnt_s   = gcnt_r;
        run_s    = run_r;
        lfsr_s   = lfsr_r;
        tdata_s  = tdata_r;
        tlast_s  = tlast_r;
        tvalid_s = tvalid_r;
        done_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start && (len != {LENW{1'b0}})) begin
                    mode_s   = mode;
                    len_s    = len;
                    gap_s    = gap;
                    npkt_s   = npkt;
                    beat_s   = {LENW{1'b0}};
                    pkt_s    = {PKTW{1'b0}};
                    run_s    = {DWIDTH{1'b0}};
                    tdata_s  = beat_data(mode, {LENW{1'b0}}, {DWIDTH{1'b0}}, lfsr_r);
                    tlast_s  = (len == ONE_L);
                    tvalid_s = 1'b1;
                    state_s  = S_SEND;
                end else begin
                    tvalid_s = 1'b0;
                end
            end
            S_SEND: begin
                if (xfer_s) begin
                    lfsr_s = lfsr_adv_s;
                    run_s  = run_r + ONE_D;
                    if (last_beat_s) begin
                        beat_s = {LENW{1'b0}};
                        pkt_s  = pkt_r + ONE_P;
                        if (last_pkt_s) begin
                            state_s  = S_IDLE;
                            tvalid_s = 1'b0;
                            tlast_s  = 1'b0;
                            done_s   = 1'b1;
                        end else begin
                            // First beat of the next packet is staged now and held through any gap
                            tdata_s = beat_data(mode_r, {LENW{1'b0}}, run_r + ONE_D, lfsr_adv_s);
                            tlast_s = (len_r == ONE_L);
                            if (gap_r != {GAPW{1'b0}}) begin
                                state_s  = S_GAP;
                                tvalid_s = 1'b0;
                                gcnt_s   = gap_r;
                            end else begin
                                tvalid_s = 1'b1;
                            end
                        end
                    end else begin
                        beat_s  = beat_r + ONE_L;
                        tdata_s = beat_data(mode_r, beat_r + ONE_L, run_r + ONE_D, lfsr_adv_s);
                        tlast_s = ((beat_r + ONE_L) == len_m1_s);
                    end
                end else begin
                    tvalid_s = 1'b1;
                end
            end
            S_GAP: begin
                if (gcnt_r == ONE_G) begin
                    state_s  = S_SEND;
                    tvalid_s = 1'b1;
                end else begin
                    gcnt_s = gcnt_r - ONE_G;
                end
            end
            default: begin
                state_s  = S_IDLE;
                tvalid_s = 1'b0;
                tlast_s  = 1'b0;
            end
        endcase
        busy_s = (state_s != S_IDLE);
    end

    // FSM state register
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Configuration, counters, LFSR and registered stream outputs
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            mode_r   <= 2'd0;
            len_r    <= {LENW{1'b0}};
            gap_r    <= {GAPW{1'b0}};
            npkt_r   <= {PKTW{1'b0}};
            beat_r   <= {LENW{1'b0}};
            pkt_r    <= {PKTW{1'b0}};
            gcnt_r   <= {GAPW{1'b0}};
            run_r    <= {DWIDTH{1'b0}};
            lfsr_r   <= LFSR_INIT;
            tdata_r  <= {DWIDTH{1'b0}};
            tlast_r  <= 1'b0;
            tvalid_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            mode_r   <= mode_s;
            len_r    <= len_s;
            gap_r    <= gap_s;
            npkt_r   <= npkt_s;
            beat_r   <= beat_s;
            pkt_r    <= pkt_s;
            gcnt_r   <= gcnt_s;
            run_r    <= run_s;
            lfsr_r   <= lfsr_s;
            tdata_r  <= tdata_s;
            tlast_r  <= tlast_s;
            tvalid_r <= tvalid_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
        end
    end

    assign tvalid = tvalid_r;
    assign tdata  = tdata_r;
    assign tlast  = tlast_r;
    assign tstrb  = {(DWIDTH/8){1'b1}};
    assign busy   = busy_r;
    assign done   = done_r;

endmodule
